// File: rtl/scope_trace_reader.sv
// Purpose : reads each channel's frozen capture out of the shared capture RAM as a
//           pre-trigger window with wrap-around, then hands the buffer back to the writer.
// Latency : first sample is valid 3 edges after capture_done is sampled; at best
//           one sample every 3 cycles.
// Backpressure: smp_valid and the sample outputs hold until smp_ready. The next RAM
//           fetch starts only after the handshake. There is no combinational path
//           from smp_ready to any output.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   capture_done        one-cycle pulse; trigger_addr is valid with it
//   trigger_addr        RAM address of the trigger sample
//   abort               ends the readout (goes to DONE) from any non-IDLE state
//   rd_addr/rd_chan     registered RAM read address and channel bank
//   rd_data             RAM output, with 1-cycle read latency
//   smp_*               valid/ready sample stream to the renderer
//   buf_release         one-cycle pulse; buffer returned to the writer
//   busy, overrun       status; overrun is sticky until the next accepted capture
//
// Optional feature macro: SCOPE_READER_DECIMATE_EN adds the 3-bit 'decim' input
// (address step 2**decim, N>>decim samples per channel).
module scope_trace_reader #(
    parameter int CHANNELS = 1,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 12,
    parameter int PRETRIG  = 256,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              capture_done,
    input  logic [ADDR_W-1:0] trigger_addr,
`ifdef SCOPE_READER_DECIMATE_EN
    input  logic [2:0]        decim,
`endif
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [CH_W-1:0]   rd_chan,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] smp_data,
    output logic [CH_W-1:0]   smp_chan,
    output logic [ADDR_W-1:0] smp_index,
    output logic              smp_last,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic              buf_release,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(CHANNELS - 1);
    localparam logic [ADDR_W-1:0] PRE     = ADDR_W'(PRETRIG);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   start_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [CH_W-1:0]     chan_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [CH_W-1:0]     rd_chan_q;
    logic [DATA_W-1:0]   smp_data_q;
    logic                smp_valid_q;
    logic                overrun_q;

    // Address step shift: 0 unless decimation is built in.
    logic [2:0]          sh;
    logic [ADDR_W-1:0]   last_idx;
    logic                hs;
    logic                idx_end;
    logic                chan_end;
    logic                advance;
    logic [ADDR_W-1:0]   idx_n;
    logic [CH_W-1:0]     chan_n;
    logic [ADDR_W-1:0]   start_n;

`ifdef SCOPE_READER_DECIMATE_EN
    logic [2:0] sh_q;
    logic [2:0] decim_clamped;

    // A step of N or more would leave zero samples per channel, so clamp it.
    always_comb begin
        decim_clamped = decim;
        if (int'(decim) >= ADDR_W) begin
            decim_clamped = 3'(ADDR_W - 1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sh_q <= 3'd0;
        end else if (state_q == S_IDLE && capture_done) begin
            sh_q <= decim_clamped;
        end
    end

    assign sh = sh_q;
`else
    assign sh = 3'd0;
`endif

    assign last_idx = {ADDR_W{1'b1}} >> sh;
    assign hs       = smp_valid_q & smp_ready;
    assign idx_end  = (idx_q == last_idx);
    assign chan_end = (chan_q == LAST_CH);
    assign start_n  = trigger_addr - PRE;

    // Next position in channel-major order; only used when not on the final sample.
    always_comb begin
        idx_n  = idx_q + ADDR_W'(1);
        chan_n = chan_q;
        if (idx_end) begin
            idx_n  = '0;
            chan_n = chan_q + CH_W'(1);
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (capture_done) state_d = S_FETCH;
            S_FETCH:   state_d = abort ? S_DONE : S_WAIT;
            S_WAIT:    state_d = abort ? S_DONE : S_PRESENT;
            S_PRESENT: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (hs) begin
                    state_d = (idx_end && chan_end) ? S_DONE : S_FETCH;
                end
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // A handshake with abort in the same cycle completes but fetches nothing more,
    // since abort already steers the next state to DONE.
    assign advance = (state_q == S_PRESENT) && (state_d == S_FETCH);

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            start_q     <= '0;
            idx_q       <= '0;
            chan_q      <= '0;
            rd_addr_q   <= '0;
            rd_chan_q   <= '0;
            smp_data_q  <= '0;
            smp_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (state_q != S_IDLE && capture_done) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (capture_done) begin
                        start_q   <= start_n;
                        idx_q     <= '0;
                        chan_q    <= '0;
                        rd_addr_q <= start_n;
                        rd_chan_q <= '0;
                        overrun_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (!abort) begin
                        smp_data_q  <= rd_data;
                        smp_valid_q <= 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (hs || abort) begin
                        smp_valid_q <= 1'b0;
                    end
                    if (advance) begin
                        idx_q     <= idx_n;
                        chan_q    <= chan_n;
                        rd_addr_q <= start_q + (idx_n << sh);
                        rd_chan_q <= chan_n;
                    end
                end
                default: begin
                    smp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy        = (state_q != S_IDLE);
        buf_release = (state_q == S_DONE);
        smp_last    = smp_valid_q & idx_end & chan_end;
    end

    assign rd_addr   = rd_addr_q;
    assign rd_chan   = rd_chan_q;
    assign smp_data  = smp_data_q;
    assign smp_chan  = chan_q;
    assign smp_index = idx_q;
    assign smp_valid = smp_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_scope_trace_reader.sv
// Purpose : self-checking bench for scope_trace_reader with a {ch, addr} RAM model.
// Latency : n/a (bench).
// Backpressure: the renderer side drives smp_ready randomly, with scripted stalls.
module tb_scope_trace_reader;
    localparam int CHANNELS = 2;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 12;
    localparam int PRETRIG  = 4;
    localparam int CH_W     = 1;
    localparam int N        = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              capture_done;
    logic [ADDR_W-1:0] trigger_addr;
`ifdef SCOPE_READER_DECIMATE_EN
    logic [2:0]        decim;
`endif
    logic              abort;
    logic [ADDR_W-1:0] rd_addr;
    logic [CH_W-1:0]   rd_chan;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] smp_data;
    logic [CH_W-1:0]   smp_chan;
    logic [ADDR_W-1:0] smp_index;
    logic              smp_last;
    logic              smp_valid;
    logic              smp_ready;
    logic              buf_release;
    logic              busy;
    logic              overrun;

    scope_trace_reader #(
        .CHANNELS(CHANNELS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRETRIG(PRETRIG)
    ) dut (
        .clock(clock), .reset(reset), .capture_done(capture_done),
        .trigger_addr(trigger_addr),
`ifdef SCOPE_READER_DECIMATE_EN
        .decim(decim),
`endif
        .abort(abort), .rd_addr(rd_addr), .rd_chan(rd_chan), .rd_data(rd_data),
        .smp_data(smp_data), .smp_chan(smp_chan), .smp_index(smp_index),
        .smp_last(smp_last), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .buf_release(buf_release), .busy(busy), .overrun(overrun)
    );

    always #5 clock = ~clock;

    // Capture RAM: registered output, word content is {channel, address}.
    always @(posedge clock) rd_data <= DATA_W'({rd_chan, rd_addr});

    int checks = 0;
    int errors = 0;

    int obs_s[$];
    int exp_s[$];
    int st_err, rel_cnt, rel_cyc, last_hs, first_valid, end_cyc, abort_cyc;
    bit timed_out;
    bit valid_after_abort;

    function automatic int pk(int data, int idx, int ch, int addr, int last, int rch);
        return data | (idx << 12) | (ch << 16) | (addr << 17) | (last << 21) | (rch << 22);
    endfunction

    // Reference: expected sample stream in channel-major order.
    task automatic build_model(input int trig, input int dec);
        int sh;
        int cnt;
        int a;
        sh  = (dec >= ADDR_W) ? ADDR_W - 1 : dec;
        cnt = N >> sh;
        exp_s.delete();
        for (int ch = 0; ch < CHANNELS; ch++) begin
            for (int i = 0; i < cnt; i++) begin
                a = ((trig - PRETRIG + i * (1 << sh)) % N + N) % N;
                exp_s.push_back(pk(ch * N + a, i, ch, a,
                                   int'(ch == CHANNELS - 1 && i == cnt - 1), ch));
            end
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the first cycle of FETCH.
    task automatic start_cap(input logic [ADDR_W-1:0] trig);
        capture_done = 1'b1;
        trigger_addr = trig;
        @(negedge clock);
        capture_done = 1'b0;
    endtask

    // Renderer model: collects handshaked samples until busy drops (cycle 0 = FETCH).
    task automatic drain(input int ready_pct, input int stall_at, input int stall_len,
                         input int cap_at, input int abort_at);
        int  cyc, stall_left, prev, cur;
        bit  stalled, have_prev, r, aborted, capped;
        cyc = 0; stall_left = 0; prev = 0; stalled = 0; have_prev = 0;
        aborted = 0; capped = 0;
        obs_s.delete();
        st_err = 0; rel_cnt = 0; rel_cyc = -1; last_hs = -1; first_valid = -1;
        end_cyc = -1; abort_cyc = -1; timed_out = 0; valid_after_abort = 1'b1;
        forever begin
            if (buf_release) begin
                rel_cnt++;
                if (rel_cyc < 0) rel_cyc = cyc;
            end
            if (aborted && cyc == abort_cyc + 1) valid_after_abort = smp_valid;
            if (!busy) begin
                end_cyc = cyc;
                break;
            end
            if (cyc >= 2000) begin
                timed_out = 1;
                break;
            end
            capture_done = 1'b0;
            abort = 1'b0;
            cur = pk(int'(smp_data), int'(smp_index), int'(smp_chan), int'(rd_addr),
                     int'(smp_last), int'(rd_chan));
            r = ($urandom_range(1, 100) <= ready_pct);
            if (smp_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (have_prev && cur != prev) st_err++;
                if (!stalled && obs_s.size() == stall_at) begin
                    stalled = 1;
                    stall_left = stall_len;
                end
                if (stall_left > 0) begin
                    r = 0;
                    stall_left--;
                end
                if (!aborted && obs_s.size() == abort_at) begin
                    abort = 1'b1;
                    aborted = 1;
                    abort_cyc = cyc;
                    r = 0;
                end
                if (!capped && obs_s.size() == cap_at) begin
                    capture_done = 1'b1;
                    trigger_addr = ADDR_W'($urandom);
                    capped = 1;
                end
                if (r) begin
                    obs_s.push_back(cur);
                    last_hs = cyc;
                    have_prev = 0;
                end else begin
                    have_prev = 1;
                    prev = cur;
                end
            end else begin
                have_prev = 0;
            end
            smp_ready = r;
            @(negedge clock);
            cyc++;
        end
        capture_done = 1'b0;
        abort = 1'b0;
        smp_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({rd_addr, rd_chan, smp_data, smp_chan, smp_index, smp_last, smp_valid,
             buf_release, busy, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%0d data=%0d idx=%0d valid=%b rel=%b busy=%b ovr=%b, expected all 0",
                     rd_addr, smp_data, smp_index, smp_valid, buf_release, busy, overrun);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || smp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b valid=%b, expected 0 0", busy, smp_valid);
        end
    endtask

    task automatic test_basic_wrap;
        build_model(2, 0);
        start_cap(4'd2);
        drain(100, -1, 0, -1, -1);
        checks++;
        if (timed_out) begin errors++; $display("FAIL basic_timeout: got no end of readout, expected busy to drop"); end
        checks++;
        if (obs_s.size() != exp_s.size()) begin
            errors++;
            $display("FAIL basic_count: got %0d samples, expected %0d", obs_s.size(), exp_s.size());
        end else foreach (exp_s[k]) begin
            checks++;
            if (obs_s[k] !== exp_s[k]) begin
                errors++;
                $display("FAIL basic_sample[%0d]: got %h, expected %h", k, obs_s[k], exp_s[k]);
            end
        end
        checks++;
        if (first_valid != 2) begin errors++; $display("FAIL basic_latency: got first valid at cycle %0d, expected 2", first_valid); end
        checks++;
        if (last_hs != 3 * N * CHANNELS - 1) begin errors++; $display("FAIL basic_throughput: got last handshake at %0d, expected %0d", last_hs, 3 * N * CHANNELS - 1); end
        checks++;
        if (rel_cnt != 1 || rel_cyc != last_hs + 1) begin
            errors++;
            $display("FAIL release_pulse: got %0d pulses at cycle %0d, expected 1 at %0d", rel_cnt, rel_cyc, last_hs + 1);
        end
        checks++;
        if (end_cyc != rel_cyc + 1) begin errors++; $display("FAIL busy_drop: got idle at %0d, expected %0d", end_cyc, rel_cyc + 1); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b, expected 0", overrun); end
    endtask

    task automatic test_random_ready;
        int trig;
        for (int it = 0; it < 4; it++) begin
            trig = $urandom_range(0, N - 1);
            build_model(trig, 0);
            start_cap(ADDR_W'(trig));
            drain($urandom_range(30, 90), -1, 0, -1, -1);
            checks++;
            if (obs_s.size() != exp_s.size() || timed_out) begin
                errors++;
                $display("FAIL random_count: got %0d samples (timeout=%b), expected %0d", obs_s.size(), timed_out, exp_s.size());
            end else foreach (exp_s[k]) begin
                checks++;
                if (obs_s[k] !== exp_s[k]) begin
                    errors++;
                    $display("FAIL random_sample[%0d]: got %h, expected %h", k, obs_s[k], exp_s[k]);
                end
            end
            checks++;
            if (st_err != 0 || rel_cnt != 1) begin
                errors++;
                $display("FAIL random_hold: got %0d unstable cycles and %0d releases, expected 0 and 1", st_err, rel_cnt);
            end
        end
    endtask

    task automatic test_backpressure;
        int trig;
        trig = $urandom_range(0, N - 1);
        build_model(trig, 0);
        start_cap(ADDR_W'(trig));
        drain(100, 5, 10, -1, -1);
        checks++;
        if (st_err != 0) begin errors++; $display("FAIL bp_stable: got %0d changes while stalled, expected 0", st_err); end
        checks++;
        if (obs_s.size() != exp_s.size() || timed_out) begin
            errors++;
            $display("FAIL bp_count: got %0d samples, expected %0d", obs_s.size(), exp_s.size());
        end else foreach (exp_s[k]) begin
            checks++;
            if (obs_s[k] !== exp_s[k]) begin
                errors++;
                $display("FAIL bp_sample[%0d]: got %h, expected %h", k, obs_s[k], exp_s[k]);
            end
        end
        checks++;
        if (last_hs != 3 * N * CHANNELS - 1 + 10) begin errors++; $display("FAIL bp_timing: got last handshake at %0d, expected %0d", last_hs, 3 * N * CHANNELS + 9); end
    endtask

    task automatic test_overrun;
        int trig;
        trig = $urandom_range(0, N - 1);
        build_model(trig, 0);
        start_cap(ADDR_W'(trig));
        drain(100, -1, 0, 5, -1);
        checks++;
        if (obs_s.size() != exp_s.size() || timed_out) begin
            errors++;
            $display("FAIL ovr_count: got %0d samples, expected %0d", obs_s.size(), exp_s.size());
        end else foreach (exp_s[k]) begin
            checks++;
            if (obs_s[k] !== exp_s[k]) begin
                errors++;
                $display("FAIL ovr_sample[%0d]: got %h, expected %h", k, obs_s[k], exp_s[k]);
            end
        end
        checks++;
        if (overrun !== 1'b1 || rel_cnt != 1) begin
            errors++;
            $display("FAIL ovr_flag: got overrun=%b releases=%0d, expected 1 and 1", overrun, rel_cnt);
        end
        start_cap(4'd9);
        checks++;
        if (overrun !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ovr_clear: got overrun=%b busy=%b, expected 0 1", overrun, busy);
        end
        drain(100, -1, 0, -1, -1);
    endtask

    task automatic test_abort;
        build_model(6, 0);
        start_cap(4'd6);
        drain(100, -1, 0, -1, 7);
        checks++;
        if (obs_s.size() != 7 || timed_out) begin
            errors++;
            $display("FAIL abort_count: got %0d samples, expected 7", obs_s.size());
        end else foreach (obs_s[k]) begin
            checks++;
            if (obs_s[k] !== exp_s[k]) begin
                errors++;
                $display("FAIL abort_sample[%0d]: got %h, expected %h", k, obs_s[k], exp_s[k]);
            end
        end
        checks++;
        if (valid_after_abort !== 1'b0) begin errors++; $display("FAIL abort_valid: got smp_valid=%b after abort, expected 0", valid_after_abort); end
        checks++;
        if (rel_cnt != 1 || rel_cyc != abort_cyc + 1) begin
            errors++;
            $display("FAIL abort_release: got %0d pulses at %0d, expected 1 at %0d", rel_cnt, rel_cyc, abort_cyc + 1);
        end
    endtask

    task automatic test_reset_mid;
        int rels;
        rels = 0;
        start_cap(4'd11);
        smp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            capture_done = (c == 4);
            if (buf_release) rels++;
            @(negedge clock);
        end
        capture_done = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        smp_ready = 1'b0;
        checks++;
        if ({rd_addr, rd_chan, smp_data, smp_chan, smp_index, smp_last, smp_valid,
             buf_release, busy, overrun} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got addr=%0d data=%0d idx=%0d valid=%b busy=%b ovr=%b, expected all 0",
                     rd_addr, smp_data, smp_index, smp_valid, busy, overrun);
        end
        for (int c = 0; c < 8; c++) begin
            if (buf_release) rels++;
            @(negedge clock);
        end
        checks++;
        if (rels != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release: got %0d releases busy=%b, expected 0 0", rels, busy);
        end
    endtask

`ifdef SCOPE_READER_DECIMATE_EN
    task automatic test_decimate;
        int dv[2];
        int tv[2];
        dv[0] = 2; tv[0] = 4;
        dv[1] = 7; tv[1] = 13;
        for (int t = 0; t < 2; t++) begin
            build_model(tv[t], dv[t]);
            decim = 3'(dv[t]);
            start_cap(ADDR_W'(tv[t]));
            decim = 3'd0;
            drain(100, -1, 0, -1, -1);
            checks++;
            if (obs_s.size() != exp_s.size() || timed_out) begin
                errors++;
                $display("FAIL decim_count: got %0d samples, expected %0d", obs_s.size(), exp_s.size());
            end else foreach (exp_s[k]) begin
                checks++;
                if (obs_s[k] !== exp_s[k]) begin
                    errors++;
                    $display("FAIL decim_sample[%0d]: got %h, expected %h", k, obs_s[k], exp_s[k]);
                end
            end
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of simulation, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        capture_done = 1'b0;
        trigger_addr = '0;
        abort = 1'b0;
        smp_ready = 1'b0;
`ifdef SCOPE_READER_DECIMATE_EN
        decim = 3'd0;
`endif
        @(negedge clock);
        test_reset();
        test_basic_wrap();
        test_random_ready();
        test_backpressure();
        test_overrun();
        test_abort();
        test_reset_mid();
`ifdef SCOPE_READER_DECIMATE_EN
        test_decimate();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scope_trace_reader.md
# scope_trace_reader

Read side of the oscilloscope capture buffer. When the acquisition writer freezes a capture and pulses `capture_done`, this block reads every channel's trace out of the shared capture RAM. Each channel is read as a pre-trigger window starting relative to the trigger address, with wrap-around. Samples are streamed with valid/ready to the display renderer, and the buffer is handed back to the writer with `buf_release`.

## Interface
- `CHANNELS`, 1: number of scope channels stored in the RAM.
- `ADDR_W`, 10: per-channel sample address width; trace length `N = 2**ADDR_W`.
- `DATA_W`, 12: sample width (LTC2308 ADC resolution).
- `PRETRIG`, 256: samples shown before the trigger point; `0 <= PRETRIG < N`.
- `CH_W`, derived as `max(1, $clog2(CHANNELS))`; not user-set.

Ports:
- `clock` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `capture_done` in 1: one-cycle pulse, buffer frozen and valid.
- `trigger_addr` in ADDR_W: RAM address of the trigger sample, valid with `capture_done`.
- `abort` in 1: stop readout and release the buffer.
- `rd_addr` out ADDR_W: RAM read address, registered.
- `rd_chan` out CH_W: RAM read channel bank, registered.
- `rd_data` in DATA_W: RAM output, registered inside the RAM, 1-cycle read latency.
- `smp_data` out DATA_W: sample to the renderer.
- `smp_chan` out CH_W: channel of `smp_data`.
- `smp_index` out ADDR_W: screen column, 0 = leftmost.
- `smp_last` out 1: final sample of the final channel.
- `smp_valid` out 1: sample presented.
- `smp_ready` in 1: renderer accepts.
- `buf_release` out 1: one-cycle pulse, buffer returned to the writer.
- `busy` out 1: high in any state other than IDLE.
- `overrun` out 1: sticky; set when a capture arrives while busy.

## Operation
- States are IDLE, FETCH, WAIT, PRESENT and DONE.
- IDLE:
  - `capture_done` → latch `start = trigger_addr - PRETRIG` (mod N), channel = 0, index = 0, then go to FETCH.
  - Accepting a capture in IDLE clears `overrun`.
- FETCH: `rd_addr = start + index` (mod N) and `rd_chan = channel` are held; next state is WAIT.
- WAIT: the RAM data becomes valid. At the end of WAIT, register `rd_data` into `smp_data`, set `smp_valid`, and go to PRESENT.
- PRESENT:
  - `smp_valid` and the sample outputs are held stable until `smp_valid & smp_ready`.
  - On handshake with index < N-1: increment index and go to FETCH.
  - On handshake with index = N-1 and channel < CHANNELS-1: reset index to 0, increment channel, and go to FETCH.
  - On handshake with `smp_last`: go to DONE.
- DONE: `buf_release` is high for exactly one cycle, then the block returns to IDLE.
- Order is channel-major. Address arithmetic is ADDR_W-bit unsigned with natural wrap; there is no saturation.
- `smp_last = (channel == CHANNELS-1) & (index == N-1)`, qualified by `smp_valid`.
- `capture_done` while busy: ignored, sets `overrun`, and the current readout is unaffected.
- `abort` in any non-IDLE state: the next state is DONE and `smp_valid` drops on the next edge. `abort` in IDLE is ignored.
- When `abort` and `smp_ready` occur in the same cycle, the handshake completes but no further sample is fetched.
- Reset mid-readout: the block returns to IDLE with no `buf_release`. The writer is reset by the same `reset`.

## Timing
- Reset values: all outputs 0, state IDLE.
- `capture_done` is sampled at edge E0. FETCH runs from E0 to E1 and WAIT from E1 to E2. `smp_valid` is high from E2, i.e. 3 edges after sampling counting E0.
- Throughput is at best one sample per 3 cycles with `smp_ready` held high. Trace readout takes 3·N·CHANNELS cycles plus DONE.
- `buf_release` is high in the cycle after the final handshake edge. `busy` drops on the following edge.
- `smp_ready` may be high before `smp_valid`; the block has no combinational path from `smp_ready` to any output.

## Configuration
- `SCOPE_READER_DECIMATE_EN` defined: adds input `decim` (3 bits, sampled with `capture_done`).
  - The address step becomes `2**decim`, so `rd_addr = start + (index << decim)`.
  - Samples per channel become `N >> decim`; `smp_index` still counts 0,1,2,….
  - `smp_last` is set at index `(N >> decim) - 1`.
  - `decim >= ADDR_W` is clamped to `ADDR_W - 1`.
- Undefined: no `decim` port and the step is 1.

## Test plan
Bench settings: CHANNELS=2, ADDR_W=4, PRETRIG=4, DATA_W=12. The RAM model returns `{ch, addr}`.

- Basic wrap: `trigger_addr = 2` → `rd_addr` sequence 14,15,0,…,13 for ch0 then ch1. `smp_data` matches, `smp_index` runs 0..15, and there are 32 samples total.
- Last and release: final ch1 handshake → `smp_last` high only on that sample. `buf_release` is high for exactly 1 cycle the next cycle, then `busy` goes 0.
- Backpressure: `smp_ready` held low for 10 cycles mid-trace → `smp_data`/`smp_index` are stable and there are no lost or duplicate samples.
- Overrun: `capture_done` at sample 5 → readout unchanged and `overrun` = 1. The next accepted capture clears it.
- Abort and reset:
  - `abort` at ch0 index 7 → `smp_valid` is 0 next edge, followed by a single `buf_release`.
  - `reset` mid-trace → all outputs 0 and no `buf_release`.
- With `SCOPE_READER_DECIMATE_EN`, `decim = 2`, `trigger_addr = 4` → addresses 0,4,8,12 per channel and `smp_last` at index 3 of ch1.
